// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch
// port (I, read-only) and the memory-stage port (D, load/store). One
// transaction is outstanding at a time. D has fixed priority; a streak counter
// forces an I grant once STARVE_MAX consecutive D grants were made while I was
// waiting.
//
// Handshake: a requester raises req_i and holds it with stable fields until it
// sees gnt_o high for one cycle; the grant captures the fields, so the
// requester may change them from the next cycle on. The memory side holds
// mem_req_o and its fields stable until mem_gnt_i, then answers with one
// mem_rvalid_i pulse, which is passed straight through to the owner's
// rvalid_o/rdata_o in the same cycle.
//
// Build option: define MEM_ARB_TIMEOUT_EN to add a watchdog that ends a
// transaction with an error response after TIMEOUT_CYCLES in ISSUE+WAIT.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            i_req_i,
    input  logic [XLEN-1:0] i_addr_i,
    output logic            i_gnt_o,
    output logic            i_rvalid_o,
    output logic [XLEN-1:0] i_rdata_o,
    output logic            i_err_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [3:0]      d_be_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            d_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

    state_e          state_q, state_d;
    logic [3:0]      streak_q, streak_d;
    logic            owner_is_d_q, owner_is_d_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            timeout_hit;
    logic            arb_en;
    logic            rsp_valid;
    logic            rsp_err;
    logic            i_gnt;
    logic            d_gnt;
    logic [XLEN-1:0] rsp_data;

    // State, streak and captured request fields; reset abandons any transaction.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            streak_q     <= 4'd0;
            owner_is_d_q <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            owner_is_d_q <= owner_is_d_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next state, response generation and arbitration (IDLE or the WAIT ack cycle).
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        owner_is_d_d = owner_is_d_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        arb_en       = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_ISSUE: begin
                // mem_rvalid_i is deliberately ignored here: nothing is in flight yet.
                if (timeout_hit) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_valid = 1'b1;
                    state_d   = ST_IDLE;
                    arb_en    = 1'b1;
                end else if (timeout_hit) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb_en && rstn_i) begin
            if (d_req_i && !(i_req_i && (streak_q == STREAK_LIMIT))) begin
                d_gnt        = 1'b1;
                state_d      = ST_ISSUE;
                owner_is_d_d = 1'b1;
                we_d         = d_we_i;
                be_d         = d_be_i;
                addr_d       = d_addr_i;
                wdata_d      = d_wdata_i;
                if (!i_req_i) begin
                    streak_d = 4'd0;
                end else if (streak_q != STREAK_LIMIT) begin
                    streak_d = streak_q + 4'd1;
                end
            end else if (i_req_i) begin
                i_gnt        = 1'b1;
                state_d      = ST_ISSUE;
                owner_is_d_d = 1'b0;
                we_d         = 1'b0;
                be_d         = 4'hF;
                addr_d       = i_addr_i;
                wdata_d      = '0;
                streak_d     = 4'd0;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;

    // Watchdog count: restarts on each entry to ISSUE, saturates at the limit.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
            tmo_d = '0;
        end else if ((state_q != ST_IDLE) && (tmo_q != TMO_LIMIT)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_hit = (state_q != ST_IDLE) && (tmo_q == TMO_LIMIT);
`else
    // No watchdog in this build: the limit has no effect and the flag stays low.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign rsp_data    = rsp_err ? '0 : mem_rdata_i;

    assign i_gnt_o     = i_gnt;
    assign d_gnt_o     = d_gnt;

    assign i_rvalid_o  = rsp_valid & ~owner_is_d_q;
    assign i_rdata_o   = i_rvalid_o ? rsp_data : '0;
    assign i_err_o     = i_rvalid_o & rsp_err;

    assign d_rvalid_o  = rsp_valid & owner_is_d_q;
    assign d_rdata_o   = d_rvalid_o ? rsp_data : '0;
    assign d_err_o     = d_rvalid_o & rsp_err;

    assign mem_req_o   = (state_q == ST_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and a random-latency
// memory, checked against a transaction-level reference model and a response
// scoreboard.
module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic            own_d;
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    // ---------------- clock / DUT signals ----------------
    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            i_req_i = 1'b0;
    logic [XLEN-1:0] i_addr_i = '0;
    logic            i_gnt_o, i_rvalid_o, i_err_o;
    logic [XLEN-1:0] i_rdata_o;
    logic            d_req_i = 1'b0;
    logic            d_we_i = 1'b0;
    logic [3:0]      d_be_i = 4'd0;
    logic [XLEN-1:0] d_addr_i = '0;
    logic [XLEN-1:0] d_wdata_i = '0;
    logic            d_gnt_o, d_rvalid_o, d_err_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
    logic            mem_gnt_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [XLEN-1:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .XLEN(XLEN), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    // reference model state
    bit   txn_active   = 1'b0;
    bit   txn_accepted = 1'b0;
    int   streak       = 0;
    req_t req_q[$];
    logic [XLEN:0] exp_q[$];   // {owner_is_d, rdata}
    byte  seq_q[$];            // observed grant order, 'D' / 'I'

    // monitor -> driver notifications
    bit i_gnt_seen   = 1'b0;
    bit d_gnt_seen   = 1'b0;
    bit mem_acc_seen = 1'b0;
    bit acc_owner_d  = 1'b0;

    // stimulus controls
    int i_rate      = 0;
    int d_rate      = 0;
    int rst_hold    = 3;
    bit rst_in_wait = 1'b0;
    bit stray_next  = 1'b0;
    bit mem_busy    = 1'b0;
    int mem_delay   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: requesters and memory ----------------
    initial begin : driver
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_acc_seen) begin
                mem_acc_seen = 1'b0;
                mem_busy     = 1'b1;
                mem_delay    = $urandom_range(0, 3);
            end
            if (rst_hold > 0 || (rst_in_wait && mem_busy)) begin
                if (rst_hold > 0) rst_hold--;
                rst_in_wait  = 1'b0;
                rstn_i       = 1'b0;
                i_req_i      = 1'b0;
                d_req_i      = 1'b0;
                i_gnt_seen   = 1'b0;
                d_gnt_seen   = 1'b0;
                mem_busy     = 1'b0;
                mem_gnt_i    = 1'b0;
                mem_rvalid_i = 1'b0;
                stray_next   = 1'b1;
            end else begin
                rstn_i = 1'b1;
                if (i_gnt_seen) begin
                    i_gnt_seen = 1'b0;
                    i_req_i    = 1'b0;
                end
                if (!i_req_i && $urandom_range(1, 100) <= i_rate) begin
                    i_req_i  = 1'b1;
                    i_addr_i = $urandom;
                end
                if (d_gnt_seen) begin
                    d_gnt_seen = 1'b0;
                    d_req_i    = 1'b0;
                end
                if (!d_req_i && $urandom_range(1, 100) <= d_rate) begin
                    d_req_i   = 1'b1;
                    d_we_i    = 1'($urandom_range(0, 1));
                    d_be_i    = 4'($urandom_range(1, 15));
                    d_addr_i  = $urandom;
                    d_wdata_i = $urandom;
                end
                mem_gnt_i    = mem_req_o && ($urandom_range(0, 99) < 60);
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = $urandom;
                if (mem_busy) begin
                    if (mem_delay == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_busy     = 1'b0;
                        exp_q.push_back({acc_owner_d, mem_rdata_i});
                    end else begin
                        mem_delay--;
                    end
                end else if (stray_next || $urandom_range(0, 9) == 0) begin
                    mem_rvalid_i = 1'b1;
                end
                stray_next = 1'b0;
            end
        end
    end

    // ---------------- monitor: reference model and scoreboard ----------------
    initial begin : monitor
        logic [1:0] exp_g;
        logic       resp_now;
        logic       exp_mreq;
        req_t       r;
        logic [XLEN:0] e;
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            resp_now = txn_active && txn_accepted && mem_rvalid_i;

            // grant decision from the arbitration rule
            exp_g = 2'b00;
            if (rstn_i && (!txn_active || resp_now)) begin
                if (d_req_i && !(i_req_i && streak == STARVE_MAX)) exp_g = 2'b01;
                else if (i_req_i) exp_g = 2'b10;
            end
            check("gnt", 64'({i_gnt_o, d_gnt_o}), 64'(exp_g));

            // memory-side request and its captured fields
            exp_mreq = txn_active && !txn_accepted;
            check("mem_req", 64'(mem_req_o), 64'(exp_mreq));
            if (mem_req_o && exp_mreq && req_q.size() != 0) begin
                r = req_q[0];
                check("mem_addr", 64'(mem_addr_o), 64'(r.addr));
                check("mem_we", 64'(mem_we_o), 64'(r.we));
                check("mem_be", 64'(mem_be_o), 64'(r.be));
                if (r.we) check("mem_wdata", 64'(mem_wdata_o), 64'(r.wdata));
                if (mem_gnt_i) begin
                    void'(req_q.pop_front());
                    txn_accepted = 1'b1;
                    acc_owner_d  = r.own_d;
                    mem_acc_seen = 1'b1;
                end
            end

            // responses
            if (resp_now) begin
                txn_active   = 1'b0;
                txn_accepted = 1'b0;
            end
            if (i_rvalid_o || d_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_spurious", 64'({i_rvalid_o, d_rvalid_o}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 64'({i_rvalid_o, d_rvalid_o}), e[XLEN] ? 64'(1) : 64'(2));
                    check("rsp_data", 64'(e[XLEN] ? d_rdata_o : i_rdata_o), 64'(e[XLEN-1:0]));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_missing", 64'({i_rvalid_o, d_rvalid_o}), e[XLEN] ? 64'(1) : 64'(2));
            end
            if (!i_rvalid_o) check("i_rdata_idle", 64'(i_rdata_o), 64'(0));
            if (!d_rvalid_o) check("d_rdata_idle", 64'(d_rdata_o), 64'(0));
            check("err", 64'({i_err_o, d_err_o}), 64'(0));

            // model update on the expected grant
            if (i_gnt_o || d_gnt_o) seq_q.push_back(d_gnt_o ? 8'd68 : 8'd73);
            if (exp_g == 2'b01) begin
                r = '{own_d: 1'b1, we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};
                req_q.push_back(r);
                if (!i_req_i) streak = 0;
                else if (streak < STARVE_MAX) streak++;
            end else if (exp_g == 2'b10) begin
                r = '{own_d: 1'b0, we: 1'b0, be: 4'hF, addr: i_addr_i, wdata: '0};
                req_q.push_back(r);
                streak = 0;
            end
            if (exp_g != 2'b00) begin
                txn_active   = 1'b1;
                txn_accepted = 1'b0;
            end
            if (i_gnt_o) i_gnt_seen = 1'b1;
            if (d_gnt_o) d_gnt_seen = 1'b1;

            if (!rstn_i) begin
                txn_active   = 1'b0;
                txn_accepted = 1'b0;
                streak       = 0;
                mem_acc_seen = 1'b0;
                i_gnt_seen   = 1'b0;
                d_gnt_seen   = 1'b0;
                req_q.delete();
                exp_q.delete();
                seq_q.delete();
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        repeat (5) @(negedge clk_i);

        // Both sides requesting continuously from reset: D x STARVE_MAX, then I, then D.
        rst_hold = 1;
        i_rate   = 100;
        d_rate   = 100;
        repeat (40) @(negedge clk_i);
        check("seq_len", 64'(seq_q.size() >= 6), 64'(1));
        for (int k = 0; k < 6; k++) begin
            if (k < seq_q.size())
                check("grant_seq", 64'(seq_q[k]), (k == STARVE_MAX) ? 64'(73) : 64'(68));
        end

        // Random traffic mixes.
        for (int p = 0; p < 8; p++) begin
            i_rate = $urandom_range(5, 100);
            d_rate = $urandom_range(5, 100);
            repeat (400) @(negedge clk_i);
        end

        // Reset while a transaction waits for its response, then resume.
        for (int p = 0; p < 5; p++) begin
            i_rate      = 60;
            d_rate      = 60;
            rst_in_wait = 1'b1;
            for (int w = 0; w < 200 && rst_in_wait; w++) @(negedge clk_i);
            check("rst_in_wait_reached", 64'(rst_in_wait), 64'(0));
            repeat (50) @(negedge clk_i);
        end

        // Drain.
        i_rate = 0;
        d_rate = 0;
        for (int w = 0; w < 300 && (txn_active || i_req_i || d_req_i || exp_q.size() != 0); w++)
            @(negedge clk_i);
        check("drain", 64'({txn_active, i_req_i, d_req_i}), 64'(0));
        check("req_q_empty", 64'(req_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
